tile_ram_arbiter: RTL

TILE_RAM_ARBITER -- requirements
Module: tile_ram_arbiter

---
 rtl/tile_ram_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/tile_ram_arbiter.sv
// tile_ram_arbiter
// Round-robin arbiter that shares one single-port synchronous tile RAM between
// pacman (requester 0) and the ghosts (requesters 1..N_REQ-1). Each transaction
// walks IDLE -> ISSUE -> CAPTURE, so one access completes every three cycles.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   req        per-requester request, held until acked
//   addr_bus   tile addresses, requester i at [i*AW +: AW]
//   we0        write enable, honoured for requester 0 only
//   wdata0     write tile code for requester 0
//   ack        one-hot, one-cycle completion pulse
//   rdata      read tile code, valid while ack is high
//   busy       transaction in flight (ISSUE or CAPTURE)
//   ram_en     RAM enable
//   ram_we     RAM write enable
//   ram_addr   RAM address
//   ram_wdata  RAM write data
//   ram_rdata  RAM read data, valid one cycle after ram_en
module tile_ram_arbiter #(
    parameter int              N_REQ = 5,
    parameter int              AW    = 11,
    parameter int              DW    = 2,
    parameter int              DEPTH = 1200,
    parameter logic [DW-1:0]   WALL  = 2'b11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] addr_bus,
    input  logic                we0,
    input  logic [DW-1:0]       wdata0,
    output logic [N_REQ-1:0]    ack,
    output logic [DW-1:0]       rdata,
    output logic                busy,
    output logic                ram_en,
    output logic                ram_we,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_wdata,
    input  logic [DW-1:0]       ram_rdata
);

    localparam int          GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t          state;
    logic [GW-1:0]   g;
    logic [GW-1:0]   last_g;
    logic            oor;       // granted address was outside the map

    logic [N_REQ-1:0] eligible;
    logic             found;
    logic [GW-1:0]    win;
    logic [AW-1:0]    win_addr;
    logic             win_oor;
    int               idx;

    // A requester being acked this cycle is masked so a held req is not
    // immediately regranted.
    assign eligible = req & ~ack;

    // Round-robin search starting just after the last winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_g) + k) % N_REQ;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    assign win_addr = addr_bus[int'(win) * AW +: AW];
    assign win_oor  = {1'b0, win_addr} >= DEPTH_EXT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            g         <= '0;
            last_g    <= GW'(N_REQ - 1);
            oor       <= 1'b0;
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        g        <= win;
                        last_g   <= win;
                        oor      <= win_oor;
                        // Out-of-range accesses never touch the RAM; ghost
                        // writes degrade to reads.
                        ram_en   <= !win_oor;
                        ram_we   <= !win_oor && (win == '0) && we0;
                        ram_addr <= win_addr;
                        ram_wdata <= (win == '0) ? wdata0 : '0;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    rdata  <= oor ? WALL : ram_rdata;
                    ack[g] <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
